// File: rtl/blk_0197c3_pkg.sv
// Shared GEM descriptor layouts and constants for the descriptor-to-cookie pipe.
package blk_0197c3_pkg;

    typedef enum logic {
        GEM_MODE_RX = 1'b0,
        GEM_MODE_TX = 1'b1
    } gem_mode_e;

    localparam bit DMA_DESC_64BITADDR_DEF = 1'b1;
    localparam int GEM_TX_LEN_W           = 14;

    // RX word0: buffer address is word-aligned, so the two low bits carry wrap and own.
    typedef struct packed {
        logic [29:0] addr_hi;
        logic        wrap;
        logic        own;
    } gem_dma_rx_desc_t;

    // TX word1: used bit doubles as the ownership flag.
    typedef struct packed {
        logic                    used;
        logic                    wrap;
        logic [15:0]             rsvd;
        logic [GEM_TX_LEN_W-1:0] len;
    } gem_dma_tx_desc_t;

    function automatic logic [31:0] rx_buf_addr(input gem_dma_rx_desc_t w0);
        return {w0.addr_hi, 2'b00};
    endfunction

endpackage

// File: rtl/blk_0197c3_sync_fifo.sv
// Synchronous FIFO with a registered head entry, occupancy count and flush.
module blk_0197c3_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic                       valid_o,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign valid_o = (count_q != '0);
    assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

    // NOTE: storage is left unreset; the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clock_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            if (push_i && !do_pop) begin
                count_q <= count_q + CNT_ONE;
            end else if (!push_i && do_pop) begin
                count_q <= count_q - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/blk_0197c3.sv
// GEM DMA descriptor to DMA cookie converter: decode, ring-continuity tracking, tag
// assignment and a cookie FIFO toward the DMA engine.
module blk_0197c3
    import blk_0197c3_pkg::*;
#(
    parameter int MODE               = 0,
    parameter bit DMA_DESC_64BITADDR = DMA_DESC_64BITADDR_DEF,
    parameter int ADDR_W             = 40,
    parameter int DESC_BYTES         = 16,
    parameter int FIFO_DEPTH         = 4,
    parameter int SEQ_W              = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [ADDR_W-1:0]             in_desc_addr,
    input  logic [DESC_BYTES*8-1:0]       in_desc_words,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ADDR_W-1:0]             out_addr,
    output logic [ADDR_W-1:0]             out_data_addr,
    output logic [GEM_TX_LEN_W-1:0]       out_len,
    output logic                          out_wrap,
    output logic [SEQ_W-1:0]              out_seq,
    output logic                          out_gen,
    output logic                          out_err_unowned,
    output logic                          out_err_seq,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0]       addr;
        logic [ADDR_W-1:0]       data_addr;
        logic [GEM_TX_LEN_W-1:0] len;
        logic                    wrap;
        logic [SEQ_W-1:0]        seq;
        logic                    gen;
        logic                    err_unowned;
        logic                    err_seq;
    } dma_cookie_t;

    logic [31:0]             dec_lo;
    logic [ADDR_W-1:0]       dec_data_addr;
    logic [GEM_TX_LEN_W-1:0] dec_len;
    logic                    dec_wrap;
    logic                    dec_own;
    logic                    accept;
    logic                    err_seq;
    dma_cookie_t             cookie_in, cookie_head;
    logic [$bits(dma_cookie_t)-1:0] head_bits;

    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic              gen_q, gen_d;
    logic [ADDR_W-1:0] exp_addr_q, exp_addr_d;
    logic              exp_valid_q, exp_valid_d;

    // Not every descriptor bit matters in every layout.
    logic unused_desc_bits;
    assign unused_desc_bits = ^in_desc_words;

    if (MODE == int'(GEM_MODE_TX)) begin : g_tx
        gem_dma_tx_desc_t w1;
        logic             unused_tx_rsvd;
        assign w1             = in_desc_words[63:32];
        assign unused_tx_rsvd = ^w1.rsvd;
        assign dec_lo         = in_desc_words[31:0];
        assign dec_wrap       = w1.wrap;
        assign dec_own        = w1.used;
        assign dec_len        = w1.len;
    end else begin : g_rx
        gem_dma_rx_desc_t w0;
        assign w0       = in_desc_words[31:0];
        assign dec_lo   = rx_buf_addr(w0);
        assign dec_wrap = w0.wrap;
        assign dec_own  = w0.own;
        assign dec_len  = '0;
    end

    if (DMA_DESC_64BITADDR && ADDR_W > 32) begin : g_addr_hi
        assign dec_data_addr = {in_desc_words[64 +: ADDR_W-32], dec_lo};
    end else if (ADDR_W > 32) begin : g_addr_zero
        assign dec_data_addr = {{(ADDR_W-32){1'b0}}, dec_lo};
    end else begin : g_addr_32
        assign dec_data_addr = dec_lo;
    end

    assign in_ready = !reset && !flush && ((count < FULL_CNT) || out_ready);
    assign accept   = in_valid && in_ready;
    assign err_seq  = exp_valid_q && (in_desc_addr != exp_addr_q);

    always_comb begin
        cookie_in             = '0;
        cookie_in.addr        = in_desc_addr;
        cookie_in.data_addr   = dec_data_addr;
        cookie_in.len         = dec_len;
        cookie_in.wrap        = dec_wrap;
        cookie_in.seq         = seq_q;
        cookie_in.gen         = gen_q;
        cookie_in.err_unowned = dec_own;
        cookie_in.err_seq     = err_seq;
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        seq_d       = seq_q;
        gen_d       = gen_q;
        exp_addr_d  = exp_addr_q;
        exp_valid_d = exp_valid_q;
        if (flush) begin
            exp_valid_d = 1'b0;
        end else if (accept) begin
            seq_d       = seq_q + SEQ_W'(1);
            exp_addr_d  = in_desc_addr + ADDR_W'(DESC_BYTES);
            // After a wrap the next descriptor comes from the ring base, which we do not track.
            exp_valid_d = !dec_wrap;
            if (dec_wrap) begin
                gen_d = ~gen_q;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock) begin
        if (reset) begin
            seq_q       <= '0;
            gen_q       <= 1'b0;
            exp_addr_q  <= '0;
            exp_valid_q <= 1'b0;
        end else begin
            seq_q       <= seq_d;
            gen_q       <= gen_d;
            exp_addr_q  <= exp_addr_d;
            exp_valid_q <= exp_valid_d;
        end
    end

    blk_0197c3_sync_fifo #(
        .WIDTH ($bits(dma_cookie_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock_i     (clock),
        .reset_i     (reset),
        .flush_i     (flush),
        .push_i      (accept),
        .push_data_i (cookie_in),
        .pop_i       (out_ready),
        .valid_o     (out_valid),
        .data_o      (head_bits),
        .count_o     (count)
    );

    assign cookie_head     = head_bits;
    assign out_addr        = cookie_head.addr;
    assign out_data_addr   = cookie_head.data_addr;
    assign out_len         = cookie_head.len;
    assign out_wrap        = cookie_head.wrap;
    assign out_seq         = cookie_head.seq;
    assign out_gen         = cookie_head.gen;
    assign out_err_unowned = cookie_head.err_unowned;
    assign out_err_seq     = cookie_head.err_seq;

endmodule

// File: doc/blk_0197c3.md
Name: prism_sp_ring_acquire_cc_gem_dma_desc_2_cookie_pipe

Overview:
Parametrised, buffered successor to the combinational GEM-descriptor-to-cookie converter in the ring-acquire path.
- Accepts raw GEM DMA descriptors (RX or TX layout, 32- or 64-bit addressing) on a valid/ready stream.
- Decodes each descriptor into a DMA cookie carrying sequence and ring-generation tags, ownership and ring-continuity error flags.
- Buffers cookies in a small FIFO toward the DMA engine.
- Sits between the ring-acquire fetcher and the RX/TX DMA cookie consumers.

Parameters:
MODE, 0, 0 = GEM RX descriptor layout, 1 = GEM TX descriptor layout
DMA_DESC_64BITADDR, 1, 1 = descriptor has word2 (upper address), 64-bit buffer addresses
ADDR_W, 40, cookie address width (32..64); upper bits taken from word2 when DMA_DESC_64BITADDR
DESC_BYTES, 16, descriptor stride in bytes (8 if !DMA_DESC_64BITADDR, 16 otherwise)
FIFO_DEPTH, 4, cookie FIFO entries (power of two, >=2)
SEQ_W, 8, sequence tag width

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
flush  input  1  synchronous flush of FIFO and continuity tracker
in_valid  input  1  descriptor valid
in_ready  output  1  descriptor accepted when in_valid&in_ready
in_desc_addr  input  ADDR_W  byte address of this descriptor (dma_desc_cur)
in_desc_words  input  DESC_BYTES*8  raw descriptor, word0 at [31:0]
out_valid  output  1  cookie valid
out_ready  input  1  consumer ready
out_addr  output  ADDR_W  descriptor address
out_data_addr  output  ADDR_W  buffer byte address
out_len  output  14  TX frame length (0 in RX mode)
out_wrap  output  1  descriptor wrap bit
out_seq  output  SEQ_W  sequence tag
out_gen  output  1  ring generation bit
out_err_unowned  output  1  descriptor not owned by DMA
out_err_seq  output  1  descriptor address discontinuity
count  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset:
  - Outputs: out_valid=0, count=0, in_ready=0 during reset cycle; all cookie fields read as 0.
  - Internal state: seq=0, gen=0, exp_valid=0.
- Decode, RX:
  - data_addr[31:0] = {word0[31:2],2'b00}; wrap = word0[1]; own = word0[0]; len = 0.
- Decode, TX:
  - data_addr[31:0] = word0; wrap = word1[30]; own = word1[31]; len = word1[13:0].
- Decode, upper address:
  - If DMA_DESC_64BITADDR, data_addr[ADDR_W-1:32] = word2[ADDR_W-33:0]; else the upper bits are 0.
- err_unowned = (own==1). The cookie is still emitted; the policy decision belongs to the consumer.
- Continuity check:
  - exp_addr register tracks the expected next descriptor address.
  - err_seq = exp_valid && (in_desc_addr != exp_addr).
  - On accept: exp_addr = in_desc_addr + DESC_BYTES (mod 2^ADDR_W) and exp_valid = 1. If wrap=1, instead exp_valid = 0, because the next address is the ring base.
- Tags:
  - The cookie receives the current seq/gen; seq increments by 1 per accept (wraps mod 2^SEQ_W).
  - gen toggles after accepting a descriptor with wrap=1, so the following descriptor carries the new gen.
- FIFO:
  - Registered head; latency from accept to out_valid = 1 cycle when empty.
  - in_ready = !reset && !flush && (count<FIFO_DEPTH || out_ready). Push and pop in the same cycle are allowed when full.
  - count changes by +1 on push only, -1 on pop only, 0 on both.
  - out_valid=1 and out_ready=0: all out_* fields stay stable.
- flush:
  - Drops all entries next cycle (count=0, out_valid=0) and clears exp_valid.
  - seq and gen are retained, so tags remain monotonic across flushes.
  - in_ready=0 while flush is asserted, so no accept occurs that cycle.
- Reset asserted mid-stream: in-flight cookies are discarded and no partial state survives.

Decomposition:
- Shared package (prism_sp_config/type package):
  - gem_dma_rx_desc_t, gem_dma_tx_desc_t, and an extended dma_cookie_t (addr, data_addr, len, wrap, seq, gen, err flags).
  - Constants DMA_DESC_64BITADDR, the GEM bit positions for own/used/wrap, and GEM_TX_LEN_W=14.
- One natural sub-module, prism_sp_sync_fifo (width = $bits(dma_cookie_t), depth = FIFO_DEPTH, registered head, count output).
- Decode and tracker logic stay in the top module.

Test Plan:
- RX, 64-bit, back-to-back descriptors at 0x1000/0x1010/0x1020, word0=0x0008_0000, out_ready=1 -> cookies 1 cycle later:
  - data_addr=0x0008_0000, seq=0,1,2, gen=0, no errors.
- RX wrap:
  - Input: descriptor at 0x1030 with word0 bit1=1, then a descriptor at 0x1000.
  - Response: second cookie has gen=1 and err_seq=0.
  - Next descriptor at 0x1020 (skipping 0x1010) -> err_seq=1.
- TX mode, word1=0x4000_05EA -> wrap=1, len=0x5EA, err_unowned=0; word1=0x8000_0040 -> err_unowned=1, len=0x40.
- Backpressure, FIFO_DEPTH=4, out_ready=0, 6 offered descriptors:
  - Exactly 4 accepted, count=4, in_ready=0.
  - Head fields stable across the stall.
  - Releasing out_ready drains in order with seq 0..3.
- Full push+pop: count=4, in_valid=1 and out_ready=1 in the same cycle -> one accept and one pop, count stays 4.
- Flush with count=3 and seq=5:
  - Next cycle count=0, out_valid=0.
  - Next accepted cookie has seq=5 and err_seq=0.
  - A reset afterwards -> seq=0, gen=0.
